// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg : shared types, constants and hex glyph table for seg7     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_to_seg7 : combinational nibble to active-low 7-segment glyph    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_glyph(nibble);
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_ctrl : 4-digit multiplexed 7-seg scanner, tear-free load  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        an3,
  output logic        an2,
  output logic        an1,
  output logic        an0,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;

  logic [15:0] disp_q, disp_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_full_q, pend_full_d;

  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        boundary;
  logic        commit;
  logic        accept;
  logic        drive;
  logic [3:0]  cur_nib;
  logic [6:0]  glyph;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd3;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 2'd3;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q - 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd3;
        end
      endcase
    end
  end

  // Display regs only change at a frame boundary (or while parked), so a
  // frame never mixes two values.
  always_comb begin
    boundary    = en && (state_q == DRIVE) && (idx_q == 2'd0) && (cnt_q == CNT_SLOT_LAST);
    commit      = pend_full_q && (boundary || (state_q == IDLE));
    accept      = din_valid && !pend_full_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (commit) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = din;
      pend_dp_d   = dp_in;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  // Gating with en blanks the pins on the very next edge after en drops.
  always_comb begin
    drive        = en && (state_q == DRIVE);
    an_d         = drive ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d        = drive ? glyph : SEG_BLANK;
    dp_d         = drive ? ~disp_dp_q[idx_q] : 1'b1;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd3;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign din_ready  = ~pend_full_q;
  assign an3        = an_q[3];
  assign an2        = an_q[2];
  assign an1        = an_q[1];
  assign an0        = an_q[0];
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for seg7_scan_ctrl: position-based scan model plus directed literal checks.
module tb_seg7_scan_ctrl;

  localparam int SLOT  = 16;
  localparam int BLANK = 4;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        din_valid = 1'b0;
  logic        din_ready, an3, an2, an1, an0, dp, frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
  assign an = {an3, an2, an1, an0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  seg7_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .dp_in(dp_in),
    .din_valid(din_valid), .din_ready(din_ready),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 if (clk_run) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;  4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;  4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;  4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;  4'hE: g = 7'b0110000;  default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Model: m_pos is the position within the 64-cycle frame (-1 when parked);
  // pins show the position of the previous cycle.
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpr, m_pdp;
  bit          m_full;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, e_ready;

  initial begin
    bit m_drive, m_bnd;
    int d;
    m_pos = -1; m_disp = '0; m_pend = '0; m_dpr = '0; m_pdp = '0; m_full = 1'b0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_ready = 1'b1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pos = -1; m_disp = '0; m_pend = '0; m_dpr = '0; m_pdp = '0; m_full = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_ready = 1'b1;
      end else begin
        m_drive = en && (m_pos >= 0) && ((m_pos % SLOT) >= BLANK);
        d       = (m_pos >= 0) ? 3 - (m_pos / SLOT) : 3;
        e_an    = m_drive ? ~(4'(1) << d) : 4'hF;
        e_seg   = m_drive ? glyph(m_disp[4*d +: 4]) : 7'h7F;
        e_dp    = m_drive ? ~m_dpr[d] : 1'b1;
        m_bnd   = en && (m_pos == FRAME - 1);
        e_fd    = m_bnd;
        if (m_full && (m_bnd || m_pos < 0)) begin
          m_disp = m_pend; m_dpr = m_pdp; m_full = 1'b0;
        end else if (din_valid && !m_full) begin
          m_pend = din; m_pdp = dp_in; m_full = 1'b1;
        end
        m_pos   = !en ? -1 : ((m_pos < 0) ? 0 : (m_pos + 1) % FRAME);
        e_ready = !m_full;
      end
    end
  end

  // Per-cycle compare plus display-safety properties.
  initial begin
    logic [3:0] prev_an;
    logic [6:0] prev_seg;
    prev_an = 4'hF; prev_seg = 7'h7F;
    forever begin
      @(negedge clk);
      if (armed && !reset) begin
        chk("cyc_an", 32'(an), 32'(e_an));
        chk("cyc_seg", 32'(seg), 32'(e_seg));
        chk("cyc_dp", 32'(dp), 32'(e_dp));
        chk("cyc_frame_done", 32'(frame_done), 32'(e_fd));
        chk("cyc_din_ready", 32'(din_ready), 32'(e_ready));
        chk("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
        if (seg !== prev_seg) chk("no_tear", 32'(prev_an | an), 32'hF);
        prev_an = an; prev_seg = seg;
      end
    end
  end

  task automatic wait_an(input int i);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk); #1;
      if (an[i] == 1'b0) found = 1'b1;
    end
    if (!found) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL wait_an%0d actual=timeout expected=anode_low", i);
    end
  endtask

  task automatic wait_fd();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (frame_done) found = 1'b1;
    end
    if (!found) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL wait_frame_done actual=timeout expected=pulse");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, n;
    // 1: asynchronous reset with the clock stopped
    #1 reset = 1'b1;
    #2;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ready", 32'(din_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    armed = 1'b1;
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 2: load while parked, then scan 1234
    @(posedge clk); #1;
    din = 16'h1234; dp_in = 4'b0001; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("idle_ready_low", 32'(din_ready), 32'h0);
    @(posedge clk); #1;
    chk("idle_ready_back", 32'(din_ready), 32'h1);
    en = 1'b1;
    wait_an(3); chk("seg_an3_1", 32'(seg), 32'b1001111);
    wait_an(2); chk("seg_an2_2", 32'(seg), 32'b0010010);
    wait_an(1); chk("seg_an1_3", 32'(seg), 32'b0000110);
    wait_an(0); chk("seg_an0_4", 32'(seg), 32'b1001100);
    chk("dp_an0", 32'(dp), 32'h0);
    wait_fd(); c1 = cyc;
    @(posedge clk); #1;
    wait_fd(); c2 = cyc;
    chk("frame_period", 32'(c2 - c1), 32'(FRAME));

    // 3/4: new value mid-frame, second offer ignored while busy
    wait_an(2);
    din = 16'hABCD; dp_in = 4'b0000; din_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(din_ready), 32'h0);
    din = 16'hFFFF; dp_in = 4'b1111;
    repeat (3) begin
      @(posedge clk); #1;
      chk("busy_ignored", 32'(din_ready), 32'h0);
    end
    din_valid = 1'b0;
    wait_fd();
    repeat (2) @(posedge clk); #1;
    chk("ready_after_commit", 32'(din_ready), 32'h1);
    wait_an(3); chk("seg_an3_A", 32'(seg), 32'b0001000);
    wait_an(2); chk("seg_an2_b", 32'(seg), 32'b1100000);

    // accept exactly on the boundary cycle: held until the following boundary
    wait_fd();
    repeat (FRAME - 1) @(posedge clk); #1;
    din = 16'h5678; dp_in = 4'b1000; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("bnd_fd", 32'(frame_done), 32'h1);
    chk("bnd_accept_busy", 32'(din_ready), 32'h0);
    wait_an(3); chk("bnd_still_A", 32'(seg), 32'b0001000);

    // 5: disable during an1 drive, re-enable
    wait_an(1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_dark", 32'(an), 32'hF);
    @(posedge clk); #1;
    chk("dis_commit_ready", 32'(din_ready), 32'h1);
    en = 1'b1;
    n = 0;
    for (int k = 0; k < 50 && an == 4'hF; k++) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reen_latency", 32'(n), 32'(BLANK + 2));
    chk("reen_first_an3", 32'(an), 32'b0111);
    chk("reen_seg_5", 32'(seg), 32'b0100100);
    chk("reen_dp_an3", 32'(dp), 32'h0);

    // 6: reset pulse mid an0 drive
    wait_an(0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_ready", 32'(din_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_an(3); chk("post_rst_seg0", 32'(seg), 32'b0000001);
    chk("post_rst_dp", 32'(dp), 32'h1);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
